prm_edge_scan: RTL and testbench

//  Query sequencer for the PRM obstacle-check logic blocks (prm_oblgc_chk*).
//  - Walks a contiguous range of 15-bit edge codes and drives each code onto the

---
 rtl/prm_edge_scan.sv | 139 +++++++++++++
 tb/tb_prm_edge_scan.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/prm_edge_scan.sv
// Query sequencer for the PRM obstacle checkers: walks a code range, packs one
// result bit per edge into words and streams them out over valid/ready.
module prm_edge_scan #(
  parameter int unsigned CODE_W = 15,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CODE_W-1:0] base_code,
  input  logic [CNT_W-1:0]  count,
  output logic [CODE_W-1:0] query_code,
  output logic              query_valid,
  input  logic              edge_mask_in,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  blocked_cnt
);

  localparam int unsigned IDX_W = $clog2(WORD_W);
  localparam int unsigned REM_W = CODE_W + 1;
  localparam logic [REM_W-1:0] MAX_N = REM_W'(1) << CODE_W;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [REM_W-1:0]   remaining, rem_nxt;
  logic [WORD_W-1:0]  acc, acc_nxt;
  logic [IDX_W-1:0]   bit_idx, idx_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic [WORD_W-1:0]  wdata_nxt;
  logic               wvalid_nxt, wlast_nxt;
  logic [CNT_W-1:0]   blk_nxt;
  logic [REM_W-1:0]   count_clamped;
  logic [WORD_W-1:0]  merged;
  logic               completes, stall, adv, is_last;

  // Counts wider than the code space collapse to one full sweep.
  always_comb begin
    count_clamped = MAX_N;
    if ((64'(count)) <= (64'(MAX_N))) count_clamped = REM_W'(count);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      remaining   <= '0;
      acc         <= '0;
      bit_idx     <= '0;
      query_code  <= '0;
      query_valid <= 1'b0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_last   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blocked_cnt <= '0;
    end else begin
      state       <= state_nxt;
      remaining   <= rem_nxt;
      acc         <= acc_nxt;
      bit_idx     <= idx_nxt;
      query_code  <= code_nxt;
      query_valid <= (state_nxt == SCAN);
      word_data   <= wdata_nxt;
      word_valid  <= wvalid_nxt;
      word_last   <= wlast_nxt;
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == FIN);
      blocked_cnt <= blk_nxt;
    end
  end

  // Next-state, advance/stall and packing logic.
  always_comb begin
    state_nxt  = state;
    rem_nxt    = remaining;
    acc_nxt    = acc;
    idx_nxt    = bit_idx;
    code_nxt   = query_code;
    wdata_nxt  = word_data;
    wvalid_nxt = word_valid;
    wlast_nxt  = word_last;
    blk_nxt    = blocked_cnt;

    is_last    = (remaining == REM_W'(1));
    completes  = (bit_idx == IDX_W'(WORD_W - 1)) || is_last;
    stall      = completes && word_valid && !word_ready;
    adv        = (state == SCAN) && !stall;
    merged     = acc | (WORD_W'(edge_mask_in) << bit_idx);

    if (word_valid && word_ready) begin
      wvalid_nxt = 1'b0;
      wlast_nxt  = 1'b0;
    end

    unique case (state)
      IDLE: begin
        if (start) begin
          code_nxt  = base_code;
          rem_nxt   = count_clamped;
          blk_nxt   = '0;
          state_nxt = (count == '0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        if (adv) begin
          if (edge_mask_in && (blocked_cnt != '1)) blk_nxt = blocked_cnt + CNT_W'(1);
          if (completes) begin
            // Refill of the holding register may coincide with its acceptance.
            wdata_nxt  = merged;
            wvalid_nxt = 1'b1;
            wlast_nxt  = is_last;
            acc_nxt    = '0;
            idx_nxt    = '0;
          end else begin
            acc_nxt = merged;
            idx_nxt = bit_idx + IDX_W'(1);
          end
          code_nxt = query_code + CODE_W'(1);
          rem_nxt  = remaining - REM_W'(1);
          if (is_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (word_valid && word_ready && word_last) state_nxt = FIN;
      end
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prm_edge_scan.sv
// Randomized self-checking bench for prm_edge_scan against a list-based model
// of the expected code sequence, packed words and blocked count.
module tb_prm_edge_scan;
  localparam int unsigned CODE_W = 15;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int SPACE = 32768;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CODE_W-1:0] base_code;
  logic [CNT_W-1:0]  count;
  logic [CODE_W-1:0] query_code;
  logic              query_valid;
  logic              edge_mask_in;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  blocked_cnt;
  logic [CODE_W-1:0] mask_sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Combinational checker stand-in: parity of selected code bits.
  assign edge_mask_in = ^(query_code & mask_sel);

  prm_edge_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_code(base_code), .count(count),
    .query_code(query_code), .query_valid(query_valid), .edge_mask_in(edge_mask_in),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .busy(busy), .done(done), .blocked_cnt(blocked_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_bit(input int code, input logic [CODE_W-1:0] m);
    logic [CODE_W-1:0] c;
    c = CODE_W'(code);
    return ^(c & m);
  endfunction

  // One scan: frz >= 0 asks for query_code==frz after `hold` cycles of ready=0;
  // inj >= 0 pulses a foreign start at that cycle.
  task automatic run_scan(input string name, input int b, input int c, input int rdy_pct,
                          input int hold, input int frz, input int inj);
    logic [WORD_W-1:0] exp_words[$];
    logic [WORD_W-1:0] w;
    int n, exp_blk, cyc, budget, done_seen, busy_cyc, widx, qn, qerr, code;
    bit finished;
    logic [CODE_W-1:0] qlast;
    n = (c > SPACE) ? SPACE : c;
    exp_blk = 0; w = '0;
    for (int i = 0; i < n; i++) begin
      code = (b + i) % SPACE;
      if (ref_bit(code, mask_sel)) begin
        w[i % WORD_W] = 1'b1;
        exp_blk++;
      end
      if ((i % WORD_W) == WORD_W - 1 || i == n - 1) begin
        exp_words.push_back(w);
        w = '0;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; base_code = CODE_W'(b); count = CNT_W'(c);
    word_ready = (hold > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; budget = n * 8 + hold + 100; done_seen = 0; busy_cyc = 0;
    widx = 0; qn = 0; qerr = 0; finished = 1'b0; qlast = '0;
    while (!finished && cyc < budget) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (query_valid && (qn == 0 || query_code != qlast)) begin
        if (int'(query_code) != (b + qn) % SPACE) qerr++;
        qlast = query_code;
        qn++;
      end
      if (word_valid && word_ready) begin
        if (widx < exp_words.size()) begin
          chk({name, "_word"}, 64'(word_data), 64'(exp_words[widx]));
          chk({name, "_last"}, 64'(word_last), 64'(widx == exp_words.size() - 1));
        end
        widx++;
      end
      if (frz >= 0 && cyc == hold - 1) begin
        chk({name, "_freeze_code"}, 64'(query_code), 64'(frz));
        chk({name, "_freeze_qv"}, 64'(query_valid), 64'(1));
      end
      if (done) begin
        done_seen++;
        chk({name, "_busy_in_done"}, 64'(busy), 64'(1));
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == inj);
      if (start) begin
        base_code = CODE_W'($urandom);
        count = CNT_W'($urandom_range(1, 50));
      end
      word_ready = (cyc < hold) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
    end
    start = 1'b0;
    chk({name, "_finished"}, 64'(finished), 64'(1));
    chk({name, "_nwords"}, 64'(widx), 64'(exp_words.size()));
    chk({name, "_qseq_err"}, 64'(qerr), 64'(0));
    chk({name, "_nqueries"}, 64'(qn), 64'(n));
    chk({name, "_done_pulses"}, 64'(done_seen), 64'(1));
    if (n == 0) chk({name, "_busy_cycles"}, 64'(busy_cyc), 64'(1));
    @(negedge clk);
    chk({name, "_post_done"}, 64'({done, busy, word_valid, query_valid}), 64'(0));
    chk({name, "_blocked"}, 64'(blocked_cnt), 64'(exp_blk));
  endtask

  initial begin
    int qn;
    logic [CODE_W-1:0] qlast;
    rst_n = 1'b0; start = 1'b0; base_code = '0; count = '0; word_ready = 1'b0;
    mask_sel = CODE_W'(1);
    #12;
    chk("reset_outputs", 64'({query_code, query_valid, word_valid, word_last, busy, done,
                              blocked_cnt}), 64'(0));
    chk("reset_word", 64'(word_data), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_scan("basic5", 0, 5, 100, 0, -1, -1);
    run_scan("stall64", 0, 64, 100, 80, 63, -1);
    run_scan("wrap", 32'h7FFE, 4, 100, 0, -1, -1);
    run_scan("zero", 5, 0, 100, 0, -1, -1);

    // Reset in the middle of a scan, then a fresh scan from its own base.
    mask_sel = CODE_W'($urandom);
    @(posedge clk); #1;
    start = 1'b1; base_code = CODE_W'(16'h1234); count = CNT_W'(100); word_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    qn = 0; qlast = '0;
    for (int i = 0; i < 300 && qn < 40; i++) begin
      @(negedge clk);
      if (query_valid && (qn == 0 || query_code != qlast)) begin
        qlast = query_code;
        qn++;
      end
    end
    chk("rst_reached_q40", 64'(qn), 64'(40));
    rst_n = 1'b0;
    #1;
    chk("rst_abort_outputs", 64'({query_code, query_valid, word_valid, word_last, busy, done,
                                  blocked_cnt}), 64'(0));
    chk("rst_abort_word", 64'(word_data), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    run_scan("after_rst", 32'h0400, 70, 80, 0, -1, -1);

    mask_sel = CODE_W'($urandom);
    run_scan("inject", 32'h0100, 200, 70, 0, -1, 5);

    for (int k = 0; k < 6; k++) begin
      mask_sel = CODE_W'($urandom);
      run_scan("rand", int'($urandom_range(0, SPACE - 1)), int'($urandom_range(1, 160)),
               int'($urandom_range(20, 100)), 0, -1, -1);
    end

    mask_sel = CODE_W'($urandom);
    run_scan("clamp", 32'h0010, 40000, 100, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
